// File: rtl/pulse_meter.sv
// Measures high/low time and period of a divided pulse stream, flags out-of-tolerance
// periods and asserts lock after LOCK_N consecutive good periods.
module pulse_meter #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned EXP_HALF = 2,
  parameter int unsigned TOL      = 0,
  parameter int unsigned LOCK_N   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pulse_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             valid,
  output logic             error,
  output logic             overflow,
  output logic             lock
);

  localparam int unsigned      LK_W    = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_V   = CNT_W'(EXP_HALF);
  localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);
  localparam logic [LK_W-1:0]  LOCK_V  = LK_W'(LOCK_N);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_s1, r_s2, r_s3;
  logic [CNT_W-1:0]   r_hcnt, w_hcnt_nxt;
  logic [CNT_W-1:0]   r_lcnt, w_lcnt_nxt;
  logic [CNT_W-1:0]   r_hcap, w_hcap_nxt;
  logic               r_sat, w_sat_nxt;
  logic [LK_W-1:0]    r_lock_cnt, w_lock_cnt_nxt;
  logic [CNT_W-1:0]   w_high_nxt, w_low_nxt;
  logic [CNT_W:0]     w_period_nxt;
  logic               w_valid_nxt, w_error_nxt, w_ovf_nxt, w_lock_nxt;
  logic               w_good;

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Edge ticks run whenever out of reset, independent of enable and FSM state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      r_s1      <= pulse_in;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      rise_tick <= r_s2 & ~r_s3;
      fall_tick <= ~r_s2 & r_s3;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_hcnt     <= '0;
      r_lcnt     <= '0;
      r_hcap     <= '0;
      r_sat      <= 1'b0;
      r_lock_cnt <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period     <= '0;
      valid      <= 1'b0;
      error      <= 1'b0;
      overflow   <= 1'b0;
      lock       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hcnt     <= w_hcnt_nxt;
      r_lcnt     <= w_lcnt_nxt;
      r_hcap     <= w_hcap_nxt;
      r_sat      <= w_sat_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      high_cnt   <= w_high_nxt;
      low_cnt    <= w_low_nxt;
      period     <= w_period_nxt;
      valid      <= w_valid_nxt;
      error      <= w_error_nxt;
      overflow   <= w_ovf_nxt;
      lock       <= w_lock_nxt;
    end
  end

  assign w_good = ~r_sat
                & (abs_diff(r_hcap, EXP_V) <= TOL_V)
                & (abs_diff(r_lcnt, EXP_V) <= TOL_V);

  always_comb begin
    w_state_nxt    = r_state;
    w_hcnt_nxt     = r_hcnt;
    w_lcnt_nxt     = r_lcnt;
    w_hcap_nxt     = r_hcap;
    w_sat_nxt      = r_sat;
    w_lock_cnt_nxt = r_lock_cnt;
    w_high_nxt     = high_cnt;
    w_low_nxt      = low_cnt;
    w_period_nxt   = period;
    w_valid_nxt    = 1'b0;
    w_error_nxt    = 1'b0;
    w_ovf_nxt      = overflow;
    w_lock_nxt     = lock;

    if (!enable) begin
      w_state_nxt    = IDLE;
      w_hcnt_nxt     = '0;
      w_lcnt_nxt     = '0;
      w_sat_nxt      = 1'b0;
      w_lock_cnt_nxt = '0;
      w_lock_nxt     = 1'b0;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = WAIT_RISE;
        WAIT_RISE: begin
          if (rise_tick) begin
            w_state_nxt = MEAS_HIGH;
            w_hcnt_nxt  = 1;
            w_sat_nxt   = 1'b0;
          end
        end
        MEAS_HIGH: begin
          if (fall_tick) begin
            w_state_nxt = MEAS_LOW;
            w_hcap_nxt  = r_hcnt;
            w_lcnt_nxt  = 1;
          end else if (r_hcnt != CNT_MAX) begin
            w_hcnt_nxt = r_hcnt + 1'b1;
          end else begin
            w_sat_nxt = 1'b1;
            w_ovf_nxt = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise_tick) begin
            // Publish and restart on the same tick so no period is skipped.
            w_high_nxt   = r_hcap;
            w_low_nxt    = r_lcnt;
            w_period_nxt = {1'b0, r_hcap} + {1'b0, r_lcnt};
            w_valid_nxt  = 1'b1;
            w_error_nxt  = ~w_good;
            w_ovf_nxt    = r_sat;
            if (w_good) begin
              if (r_lock_cnt != LOCK_V) w_lock_cnt_nxt = r_lock_cnt + 1'b1;
              w_lock_nxt = (w_lock_cnt_nxt == LOCK_V);
            end else begin
              w_lock_cnt_nxt = '0;
              w_lock_nxt     = 1'b0;
            end
            w_state_nxt = MEAS_HIGH;
            w_hcnt_nxt  = 1;
            w_sat_nxt   = 1'b0;
          end else if (r_lcnt != CNT_MAX) begin
            w_lcnt_nxt = r_lcnt + 1'b1;
          end else begin
            w_sat_nxt = 1'b1;
            w_ovf_nxt = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: scenario table, hand-written corner sequences and random
// stimulus, all compared cycle by cycle against a timestamp-based reference model.
module tb_pulse_meter;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned EXP_HALF = 2;
  localparam int unsigned TOL      = 0;
  localparam int unsigned LOCK_N   = 3;
  localparam int          MAXV     = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             pulse_in = 1'b0;
  logic             rise_tick, fall_tick;
  logic [CNT_W-1:0] high_cnt, low_cnt;
  logic [CNT_W:0]   period;
  logic             valid, error, overflow, lock;

  pulse_meter #(.CNT_W(CNT_W), .EXP_HALF(EXP_HALF), .TOL(TOL), .LOCK_N(LOCK_N)) dut (
    .clock(clock), .reset(reset), .enable(enable), .pulse_in(pulse_in),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .high_cnt(high_cnt),
    .low_cnt(low_cnt), .period(period), .valid(valid), .error(error),
    .overflow(overflow), .lock(lock)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [30:0] outs();
    return {rise_tick, fall_tick, high_cnt, low_cnt, period, valid, error, overflow, lock};
  endfunction

  // ---------------- reference model: edges as timestamps ----------------
  typedef enum {M_IDLE, M_WAIT, M_HIGH, M_LOW} mmode_t;
  mmode_t     m_mode;
  logic [3:0] m_hist;
  int         m_k, m_trise, m_tfall, m_lockcnt;
  logic       m_rise, m_fall, m_valid, m_err, m_ovf, m_lock;
  int         m_h, m_l, m_p;

  task automatic model_clear();
    m_mode = M_IDLE; m_hist = '0; m_lockcnt = 0;
    m_rise = 0; m_fall = 0; m_valid = 0; m_err = 0; m_ovf = 0; m_lock = 0;
    m_h = 0; m_l = 0; m_p = 0; m_trise = 0; m_tfall = 0;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step();
    logic prise, pfall, sat, good;
    int hd, ld;
    m_k++;
    if (!reset) begin
      model_clear();
      return;
    end
    prise = m_rise;
    pfall = m_fall;
    m_hist = {m_hist[2:0], pulse_in};
    // a level sampled at edge n shows up as a tick after edge n+2
    m_rise = m_hist[2] & ~m_hist[3];
    m_fall = ~m_hist[2] & m_hist[3];
    m_valid = 0;
    m_err = 0;
    if (!enable) begin
      m_mode = M_IDLE; m_lockcnt = 0; m_lock = 0;
    end else begin
      case (m_mode)
        M_IDLE: m_mode = M_WAIT;
        M_WAIT: if (prise) begin m_mode = M_HIGH; m_trise = m_k - 1; end
        M_HIGH: begin
          if (pfall) begin m_tfall = m_k - 1; m_mode = M_LOW; end
          else if (m_k - m_trise > MAXV) m_ovf = 1;
        end
        M_LOW: begin
          if (prise) begin
            hd = m_tfall - m_trise;
            ld = (m_k - 1) - m_tfall;
            sat = (hd > MAXV) || (ld > MAXV);
            m_h = (hd > MAXV) ? MAXV : hd;
            m_l = (ld > MAXV) ? MAXV : ld;
            m_p = m_h + m_l;
            good = !sat && iabs(m_h - int'(EXP_HALF)) <= int'(TOL)
                        && iabs(m_l - int'(EXP_HALF)) <= int'(TOL);
            m_valid = 1;
            m_err = !good;
            m_ovf = sat;
            if (good) begin
              if (m_lockcnt < int'(LOCK_N)) m_lockcnt++;
            end else m_lockcnt = 0;
            m_lock = (m_lockcnt == int'(LOCK_N));
            m_trise = m_k - 1;
            m_mode = M_HIGH;
          end else if (m_k - m_tfall > MAXV) m_ovf = 1;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  initial begin
    model_clear();
    m_k = 0;
    #2;
    forever begin
      @(posedge clock);
      model_step();
      @(negedge clock);
      if (!reset) model_clear();
      chk("cycle_model", {1'b0, outs()},
          {1'b0, m_rise, m_fall, m_h[CNT_W-1:0], m_l[CNT_W-1:0], m_p[CNT_W:0],
           m_valid, m_err, m_ovf, m_lock});
    end
  end

  // ---------------- driver-side observation ----------------
  typedef struct {
    logic [CNT_W-1:0] h, l;
    logic [CNT_W:0]   p;
    logic             e, o, k;
  } pub_t;
  pub_t pubs[$];
  int   cyc_obs = 0, n_rise = 0, n_fall = 0, rise_at = 0, fall_at = 0, ph = 0;

  task automatic observe();
    @(negedge clock);
    cyc_obs++;
    if (valid === 1'b1) pubs.push_back('{high_cnt, low_cnt, period, error, overflow, lock});
    if (rise_tick === 1'b1) begin n_rise++; rise_at = cyc_obs; end
    if (fall_tick === 1'b1) begin n_fall++; fall_at = cyc_obs; end
  endtask

  task automatic drive(input logic p, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      pulse_in = p;
      observe();
    end
  endtask

  task automatic stream(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      pulse_in = ((ph % 4) < 2);
      ph++;
      observe();
    end
  endtask

  typedef struct {
    int unsigned      hi, lo;
    logic [CNT_W-1:0] eh, el;
    logic [CNT_W:0]   ep;
    logic             ee, elk;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] seq;
    logic       seen, lvl;
    pub_t       pz;

    tbl[0] = '{2, 2, 8'd2, 8'd2, 9'd4, 1'b0, 1'b1};
    tbl[1] = '{3, 2, 8'd3, 8'd2, 9'd5, 1'b1, 1'b0};
    tbl[2] = '{2, 2, 8'd2, 8'd2, 9'd4, 1'b0, 1'b1};
    tbl[3] = '{2, 3, 8'd2, 8'd3, 9'd5, 1'b1, 1'b0};
    tbl[4] = '{1, 3, 8'd1, 8'd3, 9'd4, 1'b1, 1'b0};
    tbl[5] = '{4, 4, 8'd4, 8'd4, 9'd8, 1'b1, 1'b0};
    tbl[6] = '{2, 2, 8'd2, 8'd2, 9'd4, 1'b0, 1'b1};

    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_state", {1'b0, outs()}, '0);
    #2 reset = 1'b1;
    enable = 1'b1;

    // scenario table: five periods of each pattern, then a low tail
    for (int i = 0; i < 7; i++) begin
      pubs.delete();
      repeat (5) begin
        drive(1'b1, tbl[i].hi);
        drive(1'b0, tbl[i].lo);
      end
      drive(1'b0, 5);
      chk($sformatf("tbl%0d_valids", i), (pubs.size() >= 4) ? 1 : 0, 1);
      pz = pubs[pubs.size() - 1];
      chk($sformatf("tbl%0d_high", i), pz.h, tbl[i].eh);
      chk($sformatf("tbl%0d_low", i), pz.l, tbl[i].el);
      chk($sformatf("tbl%0d_period", i), pz.p, tbl[i].ep);
      chk($sformatf("tbl%0d_error", i), pz.e, tbl[i].ee);
      chk($sformatf("tbl%0d_lock", i), lock, tbl[i].elk);
    end

    // stuck high beyond counter range
    drive(1'b1, 10);
    pubs.delete();
    drive(1'b1, 290);
    chk("stall_no_valid", pubs.size(), 0);
    chk("stall_overflow", overflow, 1);
    pubs.delete();
    drive(1'b0, 2);
    repeat (3) begin drive(1'b1, 2); drive(1'b0, 2); end
    chk("stall_pubs", (pubs.size() >= 2) ? 1 : 0, 1);
    if (pubs.size() >= 2) begin
      chk("stall_pub_high", pubs[0].h, 255);
      chk("stall_pub_period", pubs[0].p, 257);
      chk("stall_pub_error", pubs[0].e, 1);
      chk("stall_pub_ovf", pubs[0].o, 1);
      chk("clean_pub_ovf", pubs[1].o, 0);
      chk("clean_pub_error", pubs[1].e, 0);
    end

    // enable dropped on a locked stream
    ph = 0;
    stream(24);
    chk("pre_drop_lock", lock, 1);
    enable = 1'b0;
    pubs.delete();
    stream(1);
    chk("drop_lock_clear", lock, 0);
    stream(4);
    chk("drop_no_valid", pubs.size(), 0);
    chk("drop_hold", {high_cnt, low_cnt, period}, {8'd2, 8'd2, 9'd4});
    enable = 1'b1;
    pubs.delete();
    stream(28);
    chk("reen_pubs", (pubs.size() >= 3) ? 1 : 0, 1);
    if (pubs.size() >= 3) begin
      chk("reen_first_high", pubs[0].h, 2);
      chk("reen_lock_seq", {pubs[0].k, pubs[1].k, pubs[2].k}, 3'b001);
    end

    // asynchronous reset in the low phase
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      stream(1);
      if (fall_tick === 1'b1) seen = 1'b1;
    end
    chk("fall_seen", seen, 1);
    stream(1);
    chk("pre_reset_period", period, 4);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 chk("async_reset_clear", {1'b0, outs()}, '0);
    pulse_in = 1'b1;
    @(negedge clock);
    #2 reset = 1'b1;
    for (int e = 0; e < 5; e++) begin
      @(posedge clock);
      #1 seq[e] = rise_tick;
    end
    chk("release_rise_seq", seq, 5'b00100);

    // isolated 6-cycle pulse
    drive(1'b0, 12);
    n_rise = 0; n_fall = 0;
    rise_at = 0; fall_at = 0;
    begin
      int start;
      start = cyc_obs;
      drive(1'b1, 6);
      drive(1'b0, 12);
      chk("iso_rise_count", n_rise, 1);
      chk("iso_fall_count", n_fall, 1);
      chk("iso_tick_distance", fall_at - rise_at, 6);
      chk("iso_rise_latency", rise_at - start, 3);
    end

    // random segments with occasional enable drops
    lvl = 1'b1;
    for (int s = 0; s < 150; s++) begin
      enable = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
      drive(lvl, $urandom_range(1, 5));
      lvl = ~lvl;
    end
    enable = 1'b1;
    drive(1'b0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
